// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin arbiter sharing one Avalon-MM SDRAM slave
//
// Purpose: serves NUM_PORTS requesters one transaction at a time against the
// SDRAM controller s1 port, with registered Avalon outputs and a read watchdog.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_req/i_we           per-port request and direction (1=write)
//   i_addr/i_wdata       packed per-port address and write data
//   o_done               one-cycle completion pulse for the served port
//   o_rdata/o_err        read data / read-timeout flag, valid with o_done
//   o_busy               high while a transaction is in flight
//   avm_*                Avalon-MM master towards s1
module sdram_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16,
  parameter int RD_TIMEOUT = 1023
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_PORTS-1:0]        i_req,
  input  logic [NUM_PORTS-1:0]        i_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] i_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] i_wdata,
  output logic [NUM_PORTS-1:0]        o_done,
  output logic [DATA_W-1:0]           o_rdata,
  output logic                        o_err,
  output logic                        o_busy,
  output logic [ADDR_W-1:0]           avm_address,
  output logic [DATA_W/8-1:0]         avm_byteenable_n,
  output logic                        avm_chipselect,
  output logic                        avm_read_n,
  output logic                        avm_write_n,
  output logic [DATA_W-1:0]           avm_writedata,
  input  logic [DATA_W-1:0]           avm_readdata,
  input  logic                        avm_readdatavalid,
  input  logic                        avm_waitrequest
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CMD, WAIT_RD, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   idx;
  logic               cur_we;
  logic [CNT_W-1:0]   rd_cnt;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  // (base + off) mod NUM_PORTS, off < NUM_PORTS
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return IDX_W'(s);
  endfunction

  // Walk from the farthest candidate back to rr_ptr so the closest set
  // request (searching upward from rr_ptr with wrap) is the one that sticks.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = wrap_add(rr_ptr, k);
      if (i_req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign sel_addr         = i_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_wdata        = i_wdata[grant_idx*DATA_W +: DATA_W];
  assign avm_byteenable_n = '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      idx            <= '0;
      cur_we         <= 1'b0;
      rd_cnt         <= '0;
      avm_chipselect <= 1'b0;
      avm_read_n     <= 1'b1;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      o_done         <= '0;
      o_rdata        <= '0;
      o_err          <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_done <= '0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            idx            <= grant_idx;
            cur_we         <= i_we[grant_idx];
            avm_address    <= sel_addr;
            avm_writedata  <= sel_wdata;
            avm_chipselect <= 1'b1;
            avm_read_n     <= i_we[grant_idx];
            avm_write_n    <= ~i_we[grant_idx];
            o_busy         <= 1'b1;
            state          <= CMD;
          end
        end
        CMD: begin
          // Outputs simply hold while the slave stalls.
          if (!avm_waitrequest) begin
            avm_chipselect <= 1'b0;
            avm_read_n     <= 1'b1;
            avm_write_n    <= 1'b1;
            if (cur_we) begin
              o_done[idx] <= 1'b1;
              state       <= DONE;
            end else begin
              rd_cnt <= '0;
              state  <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          // Data arriving on the last watchdog cycle still wins over the abort.
          if (avm_readdatavalid) begin
            o_rdata     <= avm_readdata;
            o_done[idx] <= 1'b1;
            state       <= DONE;
          end else if (rd_cnt == CNT_W'(RD_TIMEOUT)) begin
            o_rdata     <= '0;
            o_err       <= 1'b1;
            o_done[idx] <= 1'b1;
            state       <= DONE;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        DONE: begin
          rr_ptr <= wrap_add(idx, 1);
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int TO = 31;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [NP-1:0]     i_req;
  logic [NP-1:0]     i_we;
  logic [NP*AW-1:0]  i_addr;
  logic [NP*DW-1:0]  i_wdata;
  logic [NP-1:0]     o_done;
  logic [DW-1:0]     o_rdata;
  logic              o_err;
  logic              o_busy;
  logic [AW-1:0]     avm_address;
  logic [DW/8-1:0]   avm_byteenable_n;
  logic              avm_chipselect;
  logic              avm_read_n;
  logic              avm_write_n;
  logic [DW-1:0]     avm_writedata;
  logic [DW-1:0]     avm_readdata;
  logic              avm_readdatavalid;
  logic              avm_waitrequest;

  int            checks = 0;
  int            errors = 0;
  int            rr_m   = 0;
  logic [DW-1:0] rdata_m = '0;
  int            g;

  always #5 i_clk = ~i_clk;

  sdram_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_done(o_done), .o_rdata(o_rdata),
    .o_err(o_err), .o_busy(o_busy), .avm_address(avm_address),
    .avm_byteenable_n(avm_byteenable_n), .avm_chipselect(avm_chipselect),
    .avm_read_n(avm_read_n), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rule: first requesting port at or after rr, wrapping around.
  function automatic int pick(input logic [NP-1:0] r, input int rr);
    for (int k = 0; k < NP; k++)
      if (r[(rr + k) % NP]) return (rr + k) % NP;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NP-1:0] v);
    int n = 0;
    int p = -1;
    for (int k = 0; k < NP; k++)
      if (v[k]) begin n++; p = k; end
    return (n == 1) ? p : -1;
  endfunction

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_we[p]            = we;
    i_addr[p*AW +: AW] = a;
    i_wdata[p*DW +: DW] = d;
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_cs"},    avm_chipselect, 1'b0);
    check({tag, "_rdn"},   avm_read_n, 1'b1);
    check({tag, "_wrn"},   avm_write_n, 1'b1);
    check({tag, "_addr"},  avm_address, '0);
    check({tag, "_wdata"}, avm_writedata, '0);
    check({tag, "_done"},  o_done, '0);
    check({tag, "_rdata"}, o_rdata, '0);
    check({tag, "_err"},   o_err, 1'b0);
    check({tag, "_busy"},  o_busy, 1'b0);
  endtask

  // One whole transaction, called during an IDLE cycle with i_req set.
  // lat = 0 means the slave never returns read data.
  task automatic serve(input int nwait, input int lat, input logic [DW-1:0] rd,
                       input bit drop, input bit rereq, output int gport);
    int            p;
    int            n;
    bit            err_m;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    p  = pick(i_req, rr_m);
    ea = i_addr[p*AW +: AW];
    ed = i_wdata[p*DW +: DW];
    ew = i_we[p];
    err_m = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!avm_chipselect && n < 20);
    check("grant_latency", 64'(n), 64'(1));
    if (drop) begin
      i_req[p] = 1'b0;
      i_addr[p*AW +: AW] = ~ea;
    end
    for (int w = 0; w <= nwait; w++) begin
      avm_waitrequest = (w < nwait);
      check("cmd_cs", avm_chipselect, 1'b1);
      check("cmd_addr", avm_address, ea);
      check("cmd_wdata", avm_writedata, ed);
      check("cmd_wrn", avm_write_n, !ew);
      check("cmd_rdn", avm_read_n, ew);
      check("cmd_busy", o_busy, 1'b1);
      check("cmd_done", o_done, '0);
      tick();
    end
    avm_waitrequest = 1'b0;
    check("post_cs", avm_chipselect, 1'b0);
    check("post_strobes", {avm_read_n, avm_write_n}, 2'b11);
    if (!ew) begin
      if (lat > 0) begin
        for (int k = 1; k < lat; k++) begin
          check("wait_done", o_done, '0);
          tick();
        end
        avm_readdatavalid = 1'b1;
        avm_readdata      = rd;
        check("wait_done", o_done, '0);
        tick();
        avm_readdatavalid = 1'b0;
        avm_readdata      = DW'($urandom);
        rdata_m = rd;
      end else begin
        for (int k = 0; k <= TO; k++) begin
          check("wd_done", o_done, '0);
          tick();
        end
        rdata_m = '0;
        err_m   = 1'b1;
      end
    end
    gport = onehot_idx(o_done);
    check("done_vec", o_done, 64'(1) << p);
    check("done_err", o_err, err_m);
    check("done_rdata", o_rdata, rdata_m);
    check("done_busy", o_busy, 1'b1);
    i_req[p] = 1'b0;
    rr_m = (p + 1) % NP;
    tick();
    check("idle_done", o_done, '0);
    check("idle_busy", o_busy, 1'b0);
    check("idle_err", o_err, 1'b0);
    if (rereq) i_req[p] = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_req = '0; i_we = '0; i_addr = '0; i_wdata = '0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    repeat (2) @(posedge i_clk);
    #1;
    reset_values("rst");
    check("rst_ben", avm_byteenable_n, '0);
    i_rst_n = 1'b1;
    tick();
    check("idle_nocs", avm_chipselect, 1'b0);

    // Port 0 write with two waitrequest cycles.
    set_port(0, 1'b1, 25'h000123, 16'hBEEF);
    i_req = 4'b0001;
    serve(2, 0, '0, 1'b0, 1'b0, g);
    check("t1_port", 64'(g), 64'(0));

    // Port 2 read, data three cycles after accept.
    set_port(2, 1'b0, 25'h1ABCDEF, 16'h0000);
    i_req = 4'b0100;
    serve(0, 3, 16'h5A5A, 1'b0, 1'b0, g);
    check("t2_port", 64'(g), 64'(2));
    check("t2_hold", o_rdata, 16'h5A5A);

    // Read watchdog, then a normal write.
    set_port(3, 1'b0, 25'h0F0F0F, 16'h0000);
    i_req = 4'b1000;
    serve(1, 0, '0, 1'b0, 1'b0, g);
    check("to_port", 64'(g), 64'(3));
    set_port(1, 1'b1, 25'h0000AA, 16'h1357);
    i_req = 4'b0010;
    serve(0, 0, '0, 1'b0, 1'b0, g);
    check("after_to_port", 64'(g), 64'(1));

    // Port 1 drops request and changes address right after grant.
    set_port(1, 1'b0, 25'h0155AA, 16'h0000);
    i_req = 4'b0010;
    serve(1, 2, 16'hC0DE, 1'b1, 1'b0, g);
    check("drop_port", 64'(g), 64'(1));

    // Reset while waiting for read data, then a stray readdatavalid.
    set_port(0, 1'b0, 25'h0ABCDE, 16'h0000);
    i_req = 4'b0001;
    tick();
    check("r6_cs", avm_chipselect, 1'b1);
    tick();
    tick();
    tick();
    #2 i_rst_n = 1'b0;
    #1;
    reset_values("async_rst");
    i_req = '0;
    tick();
    i_rst_n = 1'b1;
    avm_readdatavalid = 1'b1;
    avm_readdata = 16'h1234;
    tick();
    avm_readdatavalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stray_done", o_done, '0);
      check("stray_rdata", o_rdata, '0);
      check("stray_busy", o_busy, 1'b0);
      tick();
    end
    rr_m = 0;
    rdata_m = '0;

    // All ports requesting continuously.
    for (int p = 0; p < NP; p++)
      set_port(p, 1'b1, AW'(32'h100 + p * 16), DW'(32'hA0 + p));
    i_req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      serve($urandom_range(0, 2), 0, '0, 1'b0, 1'b1, g);
      check("rr4_order", 64'(g), 64'(t % 4));
    end

    // Only ports 1 and 3 active.
    set_port(1, 1'b0, 25'h0011, 16'h0000);
    set_port(3, 1'b0, 25'h0033, 16'h0000);
    i_req = 4'b1010;
    for (int t = 0; t < 4; t++) begin
      serve(0, 2, DW'($urandom), 1'b0, 1'b1, g);
      check("rr2_order", 64'(g), 64'((t % 2 == 0) ? 1 : 3));
    end

    // Randomized traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < NP; p++)
        set_port(p, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      i_req = i_req | NP'($urandom_range(0, 15));
      if (i_req == '0) i_req[$urandom_range(0, NP - 1)] = 1'b1;
      serve($urandom_range(0, 3),
            ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4),
            DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single Avalon-MM SDRAM controller slave (s1) between NUM_PORTS internal requesters, e.g. record writer, loop playback readers and the track mixer.
- Round-robin arbitration; one outstanding transaction at a time.
- Registered Avalon master outputs; per-port done pulse; read watchdog.
- Sits between the a-cappella core's memory clients and the SDRAM controller in the system interconnect.

Parameters:
NUM_PORTS, 4, number of requesters (2..8)
ADDR_W, 25, SDRAM word address width
DATA_W, 16, SDRAM data width
RD_TIMEOUT, 1023, max cycles waiting for readdatavalid before abort

Ports:
i_clk  in  1  system clock (50 MHz)
i_rst_n  in  1  asynchronous active-low reset
i_req  in  NUM_PORTS  request per port; held high until that port's o_done
i_we  in  NUM_PORTS  1=write, 0=read; valid with i_req
i_addr  in  NUM_PORTS*ADDR_W  packed addresses, port k at [k*ADDR_W +: ADDR_W]
i_wdata  in  NUM_PORTS*DATA_W  packed write data
o_done  out  NUM_PORTS  one-cycle completion pulse for the granted port
o_rdata  out  DATA_W  read data; valid while o_done pulses after a read
o_err  out  1  pulses together with o_done when a read timed out
o_busy  out  1  high in every state except IDLE
avm_address  out  ADDR_W  to s1 address
avm_byteenable_n  out  DATA_W/8  constant 0 (all bytes enabled)
avm_chipselect  out  1  to s1 chipselect
avm_read_n  out  1  to s1 read_n
avm_write_n  out  1  to s1 write_n
avm_writedata  out  DATA_W  to s1 writedata
avm_readdata  in  DATA_W  from s1
avm_readdatavalid  in  1  from s1
avm_waitrequest  in  1  from s1

Behaviour:
- Reset (async, any state): state IDLE; rr pointer 0; chipselect 0; read_n 1; write_n 1; address 0; writedata 0; o_done 0; o_rdata 0; o_err 0; o_busy 0; timeout counter 0.
- States: IDLE, CMD, WAIT_RD, DONE.
- IDLE: if any i_req, pick the first set bit searching from rr pointer upward with wrap. Latch index, we, addr and wdata. Next cycle enter CMD with chipselect=1 and read_n/write_n driven per we. No request: stay IDLE with all strobes inactive.
- CMD: hold all Avalon outputs stable while avm_waitrequest=1; no timeout applies here.
- CMD, waitrequest=0 on a write: deassert strobes next cycle, go to DONE.
- CMD, waitrequest=0 on a read: deassert strobes next cycle, go to WAIT_RD, clear the counter.
- WAIT_RD: counter increments each cycle.
  - avm_readdatavalid=1: capture avm_readdata into o_rdata, go to DONE.
  - Counter reaches RD_TIMEOUT first: o_rdata=0, set error flag, go to DONE.
- DONE (exactly one cycle): o_done[idx]=1; o_err=flag. Set rr pointer = idx+1 mod NUM_PORTS. Go to IDLE.
- Requester must drop i_req the cycle after it sees o_done; IDLE re-arbitrates the cycle after DONE.
- Latency with zero waitrequest:
  - Write: req sampled at edge n, strobe cycle n+1, o_done at n+2.
  - Read with controller latency L: o_done at cycle n+2+L.
- Requester dropping i_req after grant: the transaction still completes and o_done still pulses.
- Address and data changes after grant are ignored (latched copy is used).
- avm_readdatavalid outside WAIT_RD (stray or post-reset) is ignored.
- Simultaneous requests are served in rotating order: no port is starved for more than NUM_PORTS-1 transactions.
- o_rdata holds its value until the next read completes.

Test Plan:
- Port 0 write, addr 0x000123, data 0xBEEF, waitrequest high 2 cycles -> chipselect/write_n=0 held 3 cycles with stable addr/data; o_done=4'b0001 one cycle later; o_err=0.
- Port 2 read of addr 0x1ABCDEF, readdatavalid 3 cycles after accept with data 0x5A5A -> o_done=4'b0100 one cycle after valid; o_rdata=0x5A5A.
- All four ports request continuously, each re-requesting right after done -> grant order 0,1,2,3,0,1; with only ports 1 and 3 active -> alternation 1,3,1,3.
- Read with readdatavalid never asserted -> o_done and o_err pulse at RD_TIMEOUT+1 cycles after entering WAIT_RD; o_rdata=0; next request is served normally.
- i_rst_n low during WAIT_RD, then a stray readdatavalid after release -> outputs immediately at reset values; stray data ignored; o_rdata stays 0; no o_done.
- Port 1 drops i_req and changes i_addr one cycle after grant -> transaction uses the latched address; o_done[1] still pulses.
